// File: rtl/hpdl_pkg.sv
// ============================================================================
// Module      : hpdl_pkg
// Description : Shared types, control-code constants and character folding
//               for the HPDL-1414 multi-module display controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpdl_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_SETUP = 2'd1,
    WR_PULSE = 2'd2,
    WR_HOLD  = 2'd3
  } wr_state_t;

  localparam logic [7:0] c_cr    = 8'h0D;
  localparam logic [7:0] c_ff    = 8'h0C;
  localparam logic [7:0] c_bs    = 8'h08;
  localparam logic [6:0] c_space = 7'h20;

  // Returns {valid, code}; lower-case letters fold onto the display's upper-case set.
  function automatic logic [7:0] fold_char(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h5F)
      fold_char = {1'b1, b[6:0]};
    else if (b >= 8'h60 && b <= 8'h7E)
      fold_char = {1'b1, b[6:0] - 7'h20};
    else
      fold_char = 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hpdl1414_bus_writer.sv
// ============================================================================
// Module      : hpdl1414_bus_writer
// Description : SETUP/PULSE/HOLD bus timing for one HPDL-1414 digit write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdl1414_bus_writer
  import hpdl_pkg::*;
#(
  parameter int NUM_MODULES = 2,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [6:0]             i_char,
  output logic [6:0]             o_hpdl_d,
  output logic [1:0]             o_hpdl_a,
  output logic [NUM_MODULES-1:0] o_hpdl_wr,
  output logic                   o_done
);

  localparam int c_mod_w = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
  localparam int c_cnt_w = 8;

  wr_state_t            r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_mod_w-1:0]   r_mod;

  assign o_done = (r_state == WR_HOLD) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WR_IDLE;
      r_cnt     <= '0;
      r_mod     <= '0;
      o_hpdl_d  <= '0;
      o_hpdl_a  <= '0;
      o_hpdl_wr <= '1;
    end else begin
      case (r_state)
        WR_IDLE: begin
          if (i_start) begin
            o_hpdl_d <= i_char;
            o_hpdl_a <= 2'd3 - i_idx[1:0];
            r_mod    <= c_mod_w'(i_idx >> 2);
            r_cnt    <= c_cnt_w'(SETUP_CYC - 1);
            r_state  <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          if (r_cnt == '0) begin
            o_hpdl_wr <= ~(NUM_MODULES'(1) << r_mod);
            r_cnt     <= c_cnt_w'(PULSE_CYC - 1);
            r_state   <= WR_PULSE;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        WR_PULSE: begin
          if (r_cnt == '0) begin
            o_hpdl_wr <= '1;
            r_cnt     <= c_cnt_w'(HOLD_CYC - 1);
            r_state   <= WR_HOLD;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        WR_HOLD: begin
          if (r_cnt == '0) r_state <= WR_IDLE;
          else             r_cnt   <= r_cnt - c_cnt_w'(1);
        end
        default: r_state <= WR_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hpdl1414_multi_display.sv
// ============================================================================
// Module      : hpdl1414_multi_display
// Description : Character buffer, cursor and dirty-digit arbiter driving a
//               chain of HPDL-1414 modules through a shared write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdl1414_multi_display
  import hpdl_pkg::*;
#(
  parameter int NUM_MODULES = 2,
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1
) (
  input  logic                   CLK_i,
  input  logic                   RST_i,
  input  logic [7:0]             RX_DATA_i,
  input  logic                   RX_VALID_i,
  output logic                   RX_READY_o,
  input  logic                   MODE_SCROLL_i,
  output logic [6:0]             HPDL_D_o,
  output logic [1:0]             HPDL_A_o,
  output logic [NUM_MODULES-1:0] HPDL_WR_o,
  output logic                   BUSY_o
);

  localparam int c_num_digits = 4 * NUM_MODULES;
  localparam int c_idx_w      = $clog2(c_num_digits);
  localparam int c_cur_w      = $clog2(c_num_digits + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_digits - 1);
  localparam logic [c_cur_w-1:0] c_end      = c_cur_w'(c_num_digits);

  logic [6:0]              r_buf [c_num_digits];
  logic [c_num_digits-1:0] r_dirty;
  logic [c_cur_w-1:0]      r_cursor;
  logic [c_idx_w-1:0]      r_last;
  logic                    r_rx_ready;
  logic                    r_busy;
  logic                    r_mode_d;
  logic                    r_eng_busy;

  logic [6:0]              w_buf_nxt [c_num_digits];
  logic [c_num_digits-1:0] w_dirty_nxt;
  logic [c_cur_w-1:0]      w_cursor_nxt;
  logic [c_idx_w-1:0]      w_pick;
  logic [c_idx_w-1:0]      w_scan;
  logic                    w_pick_valid;
  logic                    w_start;
  logic                    w_done;
  logic                    w_accept;
  logic [7:0]              w_fold;
  logic                    w_at_end;
  logic [c_idx_w-1:0]      w_wr_idx;
  logic [c_idx_w-1:0]      w_bs_idx;

  assign w_accept   = RX_VALID_i & r_rx_ready;
  assign w_fold     = fold_char(RX_DATA_i);
  assign w_at_end   = (r_cursor == c_end);
  assign w_wr_idx   = w_at_end ? '0 : r_cursor[c_idx_w-1:0];
  assign w_bs_idx   = c_idx_w'(r_cursor - c_cur_w'(1));
  assign w_start    = w_pick_valid & ~r_eng_busy;
  assign RX_READY_o = r_rx_ready;
  assign BUSY_o     = r_busy;

  // Scan from the farthest offset down so the nearest dirty digit after r_last wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    w_scan       = '0;
    for (int off = c_num_digits; off >= 1; off--) begin
      w_scan = c_idx_w'((int'(r_last) + off) % c_num_digits);
      if (r_dirty[w_scan]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_scan;
      end
    end
  end

  // Dirty clear for the latched digit comes first so a same-cycle byte write re-marks it.
  always_comb begin
    w_buf_nxt    = r_buf;
    w_dirty_nxt  = r_dirty;
    w_cursor_nxt = r_cursor;
    if (w_start) w_dirty_nxt[w_pick] = 1'b0;
    if (w_accept) begin
      if (w_fold[7]) begin
        if (w_at_end && MODE_SCROLL_i) begin
          for (int i = 0; i < c_num_digits - 1; i++) begin
            w_buf_nxt[i] = r_buf[i+1];
            if (r_buf[i+1] != r_buf[i]) w_dirty_nxt[i] = 1'b1;
          end
          w_buf_nxt[c_num_digits-1] = w_fold[6:0];
          if (w_fold[6:0] != r_buf[c_num_digits-1]) w_dirty_nxt[c_num_digits-1] = 1'b1;
        end else begin
          w_buf_nxt[w_wr_idx]   = w_fold[6:0];
          w_dirty_nxt[w_wr_idx] = 1'b1;
          if (MODE_SCROLL_i || w_wr_idx != c_last_idx)
            w_cursor_nxt = c_cur_w'(w_wr_idx) + c_cur_w'(1);
          else
            w_cursor_nxt = '0;
        end
      end else if (RX_DATA_i == c_cr) begin
        w_cursor_nxt = '0;
      end else if (RX_DATA_i == c_ff) begin
        for (int i = 0; i < c_num_digits; i++) w_buf_nxt[i] = c_space;
        w_dirty_nxt  = '1;
        w_cursor_nxt = '0;
      end else if (RX_DATA_i == c_bs && r_cursor != '0) begin
        w_cursor_nxt          = r_cursor - c_cur_w'(1);
        w_buf_nxt[w_bs_idx]   = c_space;
        w_dirty_nxt[w_bs_idx] = 1'b1;
      end
    end
    if (r_mode_d && !MODE_SCROLL_i && w_at_end) w_cursor_nxt = '0;
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      for (int i = 0; i < c_num_digits; i++) r_buf[i] <= c_space;
      r_dirty    <= '1;
      r_cursor   <= '0;
      r_last     <= c_last_idx;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_mode_d   <= 1'b0;
      r_eng_busy <= 1'b0;
    end else begin
      r_buf      <= w_buf_nxt;
      r_dirty    <= w_dirty_nxt;
      r_cursor   <= w_cursor_nxt;
      r_rx_ready <= 1'b1;
      r_busy     <= (|r_dirty) | r_eng_busy;
      r_mode_d   <= MODE_SCROLL_i;
      if (w_start) begin
        r_last     <= w_pick;
        r_eng_busy <= 1'b1;
      end else if (w_done) begin
        r_eng_busy <= 1'b0;
      end
    end
  end

  hpdl1414_bus_writer #(
    .NUM_MODULES (NUM_MODULES),
    .SETUP_CYC   (SETUP_CYC),
    .PULSE_CYC   (PULSE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .IDX_W       (c_idx_w)
  ) u_writer (
    .clk       (CLK_i),
    .rst       (RST_i),
    .i_start   (w_start),
    .i_idx     (w_pick),
    .i_char    (r_buf[w_pick]),
    .o_hpdl_d  (HPDL_D_o),
    .o_hpdl_a  (HPDL_A_o),
    .o_hpdl_wr (HPDL_WR_o),
    .o_done    (w_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_hpdl1414_multi_display.sv
// ============================================================================
// Module      : tb_hpdl1414_multi_display
// Description : Randomised self-checking bench with a bus monitor and a
//               character-buffer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdl1414_multi_display;

  localparam int ND = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       mode = 1'b0;
  logic       rx_ready, busy, rx_ready2, busy2;
  logic [6:0] d, d2;
  logic [1:0] a, a2, wr, wr2;

  always #5 clk = ~clk;

  hpdl1414_multi_display #(.NUM_MODULES(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .CLK_i(clk), .RST_i(rst), .RX_DATA_i(rx_data), .RX_VALID_i(rx_valid), .RX_READY_o(rx_ready),
    .MODE_SCROLL_i(mode), .HPDL_D_o(d), .HPDL_A_o(a), .HPDL_WR_o(wr), .BUSY_o(busy));

  hpdl1414_multi_display #(.NUM_MODULES(2), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut_slow (
    .CLK_i(clk), .RST_i(rst), .RX_DATA_i(rx_data), .RX_VALID_i(rx_valid), .RX_READY_o(rx_ready2),
    .MODE_SCROLL_i(mode), .HPDL_D_o(d2), .HPDL_A_o(a2), .HPDL_WR_o(wr2), .BUSY_o(busy2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bus monitor: what the display modules actually received
  typedef struct { int digit; int val; } wr_ev_t;
  wr_ev_t     wlog[$];
  logic [6:0] disp[ND];
  bit         in_win = 0;
  logic [6:0] win_d;
  logic [1:0] win_a, win_wr;
  int         win_len;

  always @(negedge clk) begin
    if (rst) begin
      in_win = 0;
    end else if (wr !== 2'b11) begin
      checks++;
      if ($countones(~wr) != 1) begin
        errors++;
        $display("FAIL one_wr_low: wr=%b, required exactly one low bit", wr);
      end
      if (!in_win) begin
        in_win = 1; win_d = d; win_a = a; win_wr = wr; win_len = 1;
      end else begin
        checks++;
        if (d !== win_d || a !== win_a || wr !== win_wr) begin
          errors++;
          $display("FAIL bus_stable: d=%h a=%0d wr=%b, required d=%h a=%0d wr=%b",
                   d, a, wr, win_d, win_a, win_wr);
        end
        win_len++;
      end
    end else if (in_win) begin
      int dg;
      in_win = 0;
      checks++;
      if (win_len != 2) begin
        errors++;
        $display("FAIL wr_low_len: low for %0d cycles, required 2", win_len);
      end
      dg = (win_wr == 2'b10 ? 0 : 4) + 3 - int'(win_a);
      wlog.push_back('{dg, int'(win_d)});
      disp[dg] = win_d;
    end
  end

  bit in2 = 0;
  int len2;
  int falls2[$];
  int lens2[$];
  always @(negedge clk) begin
    if (rst) in2 = 0;
    else if (wr2 !== 2'b11) begin
      if (!in2) begin in2 = 1; len2 = 1; falls2.push_back(cyc); end
      else len2++;
    end else if (in2) begin
      in2 = 0; lens2.push_back(len2);
    end
  end

  // ---------------- reference model of the character buffer and cursor
  logic [6:0] m_buf[ND];
  int         m_cur;
  bit         m_mode;

  function automatic void m_reset();
    for (int i = 0; i < ND; i++) m_buf[i] = 7'h20;
    m_cur = 0;
  endfunction

  function automatic void m_apply(input logic [7:0] b);
    logic [6:0] c;
    if (b >= 8'h20 && b <= 8'h7E) begin
      c = (b >= 8'h60) ? 7'(b - 8'h20) : b[6:0];
      if (m_cur == ND) begin
        if (m_mode) begin
          for (int i = 0; i < ND - 1; i++) m_buf[i] = m_buf[i+1];
          m_buf[ND-1] = c;
        end
      end else begin
        m_buf[m_cur] = c;
        m_cur = (m_mode || m_cur < ND - 1) ? m_cur + 1 : 0;
      end
    end else if (b == 8'h0D) begin
      m_cur = 0;
    end else if (b == 8'h0C) begin
      m_reset();
    end else if (b == 8'h08 && m_cur > 0) begin
      m_cur--;
      m_buf[m_cur] = 7'h20;
    end
  endfunction

  // ---------------- stimulus tasks
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; m_apply(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    rx_data = b0; rx_valid = 1'b1; m_apply(b0);
    @(negedge clk);
    rx_data = b1; m_apply(b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic set_mode(input bit m);
    @(negedge clk);
    if (m_mode && !m && m_cur == ND) m_cur = 0;
    mode = m; m_mode = m;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    repeat (3) @(negedge clk);
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    int n;
    rst = 1'b1; mode = 1'b0; m_mode = 0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (d !== 7'h00)     begin errors++; $display("FAIL rst_d: got %h, required 00", d); end
    if (a !== 2'd0)      begin errors++; $display("FAIL rst_a: got %0d, required 0", a); end
    if (wr !== 2'b11)    begin errors++; $display("FAIL rst_wr: got %b, required 11", wr); end
    if (rx_ready !== 0)  begin errors++; $display("FAIL rst_ready: got %b, required 0", rx_ready); end
    if (busy !== 0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    wlog.delete(); falls2.delete(); lens2.delete();
    m_reset();
    rst = 1'b0;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    checks += 2;
    if (n != 40) begin errors++; $display("FAIL init_busy_len: busy for %0d cycles, required 40", n); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b, required 1", rx_ready); end
    checks++;
    if (wlog.size() != 8) begin
      errors++; $display("FAIL init_write_count: got %0d, required 8", wlog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[i].digit != i || wlog[i].val != 'h20) begin
          errors++;
          $display("FAIL init_write%0d: digit %0d val %h, required digit %0d val 20",
                   i, wlog[i].digit, wlog[i].val, i);
        end
      end
    end
    n = 0;
    while (busy2 !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (falls2.size() != 8 || lens2.size() != 8) begin
      errors++;
      $display("FAIL slow_write_count: got %0d/%0d, required 8", falls2.size(), lens2.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lens2[i] != 3) begin errors++; $display("FAIL slow_pulse%0d: low %0d cycles, required 3", i, lens2[i]); end
        if (i > 0) begin
          checks++;
          if (falls2[i] - falls2[i-1] != 8) begin
            errors++;
            $display("FAIL slow_spacing%0d: got %0d cycles, required 8", i, falls2[i] - falls2[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_ab();
    wlog.delete();
    send("a"); send("b");
    wait_idle("ab");
    checks++;
    if (wlog.size() != 2) begin
      errors++; $display("FAIL ab_count: %0d writes, required 2", wlog.size());
    end else begin
      checks += 2;
      if (wlog[0].digit != 0 || wlog[0].val != 'h41) begin
        errors++; $display("FAIL ab_first: digit %0d val %h, required digit 0 val 41", wlog[0].digit, wlog[0].val);
      end
      if (wlog[1].digit != 1 || wlog[1].val != 'h42) begin
        errors++; $display("FAIL ab_second: digit %0d val %h, required digit 1 val 42", wlog[1].digit, wlog[1].val);
      end
    end
  endtask

  task automatic test_wrap();
    string exp = "IBCDEFGH";
    set_mode(0);
    send(8'h0C); wait_idle("wrap_clr");
    send_str("ABCDEFGHI");
    wait_idle("wrap");
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (disp[i] !== exp[i][6:0] || disp[i] !== m_buf[i]) begin
        errors++; $display("FAIL wrap_digit%0d: shown %h, required %h", i, disp[i], exp[i][6:0]);
      end
    end
    send("z"); wait_idle("wrap_cur");
    checks++;
    if (disp[1] !== 7'h5A) begin errors++; $display("FAIL wrap_cursor: digit1 %h, required 5a", disp[1]); end
  endtask

  task automatic test_scroll();
    string exp = "BCDEFGHI";
    set_mode(1);
    send(8'h0C);
    send_str("ABCDEFGHI");
    wait_idle("scroll");
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (disp[i] !== exp[i][6:0]) begin
        errors++; $display("FAIL scroll_digit%0d: shown %h, required %h", i, disp[i], exp[i][6:0]);
      end
    end
    send(8'h08); wait_idle("scroll_bs");
    checks++;
    if (disp[7] !== 7'h20) begin errors++; $display("FAIL scroll_bs: digit7 %h, required 20", disp[7]); end
    send("Q"); wait_idle("scroll_q");
    checks++;
    if (disp[7] !== 7'h51) begin errors++; $display("FAIL scroll_bs_cursor: digit7 %h, required 51", disp[7]); end
    set_mode(0);
    send("R"); wait_idle("mode_fall");
    checks++;
    if (disp[0] !== 7'h52) begin errors++; $display("FAIL mode_fall_cursor: digit0 %h, required 52", disp[0]); end
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (disp[i] !== m_buf[i]) begin
        errors++; $display("FAIL scroll_model%0d: shown %h, required %h", i, disp[i], m_buf[i]);
      end
    end
  endtask

  task automatic test_ff_mid_refresh();
    int last_val[ND];
    for (int i = 0; i < 8; i++) send(8'($urandom_range(8'h41, 8'h5A)));
    wait_idle("ff_fill");
    wlog.delete();
    send(8'h0D);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(8'h21, 8'h5A)));
    repeat (6) @(negedge clk);
    send(8'h0C);
    wait_idle("ff");
    for (int i = 0; i < ND; i++) last_val[i] = -1;
    foreach (wlog[j]) last_val[wlog[j].digit] = wlog[j].val;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (last_val[i] != 'h20 || m_buf[i] !== 7'h20) begin
        errors++; $display("FAIL ff_digit%0d: last write %0h, required 20", i, last_val[i]);
      end
    end
  endtask

  task automatic test_collision();
    int cnt = 0;
    int first = -1;
    int last = -1;
    set_mode(1);
    send(8'h0C);
    send_str("ABCDEFGH");
    wait_idle("col_fill");
    send(8'h08);
    wait_idle("col_bs");
    send(8'h0D);
    repeat (4) @(negedge clk);
    wlog.delete();
    send2(8'h0C, "X");
    wait_idle("col");
    foreach (wlog[j]) if (wlog[j].digit == 0) begin
      cnt++;
      if (first < 0) first = wlog[j].val;
      last = wlog[j].val;
    end
    checks += 3;
    if (cnt != 2)      begin errors++; $display("FAIL col_count: digit0 written %0d times, required 2", cnt); end
    if (first != 'h20) begin errors++; $display("FAIL col_first: got %0h, required 20", first); end
    if (last != 'h58)  begin errors++; $display("FAIL col_last: got %0h, required 58", last); end
    set_mode(0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
        else if (r < 76) b = 8'h0D;
        else if (r < 79) b = 8'h0C;
        else if (r < 92) b = 8'h08;
        else             b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 19) == 0) set_mode(bit'($urandom_range(0, 1)));
        send(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rand");
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (disp[i] !== m_buf[i]) begin
          errors++; $display("FAIL rand%0d_digit%0d: shown %h, required %h", rnd, i, disp[i], m_buf[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    set_mode(0);
    send("K");
    while (wr === 2'b11 && n < 50) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wr !== 2'b11) begin errors++; $display("FAIL rst_mid_wr: wr=%b, required 11", wr); end
    repeat (2) @(negedge clk);
    m_reset();
    rst = 1'b0;
    wait_idle("rst_mid");
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (disp[i] !== m_buf[i]) begin
        errors++; $display("FAIL rst_mid_digit%0d: shown %h, required %h", i, disp[i], m_buf[i]);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ab();
    test_wrap();
    test_scroll();
    test_ff_mid_refresh();
    test_collision();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
